// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_forward_unit
//  Description : Decode-stage hazard detection and operand forwarding for an
//                in-order pipeline. In-flight register writers are tracked in
//                a DEPTH-entry shift register. The unit produces the stall,
//                issue and per-operand forward selects, and counts stall
//                cycles with a saturating counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_unit #(
   parameter int REG_ADDR_W  = 4,
   parameter int DEPTH       = 3,
   parameter int LOAD_LAT    = 2,
   parameter int ZERO_REG_EN = 1,
   parameter int CNT_W       = 16,
   parameter int SEL_W       = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_use_rs,
   input  logic                  id_use_rt,
   input  logic [REG_ADDR_W-1:0] id_dst,
   input  logic                  id_reg_write,
   input  logic                  id_is_load,
   input  logic                  id_flush,
   input  logic                  mem_hold,
   output logic                  issue,
   output logic                  stall_id,
   output logic [SEL_W-1:0]      fwd_rs_sel,
   output logic [SEL_W-1:0]      fwd_rt_sel,
   output logic [DEPTH-1:0]      stage_valid,
   output logic [CNT_W-1:0]      stall_count
);

   // Tracked entries; index k is the stage k cycles after decode.
   logic [DEPTH:1]                  r_valid;
   logic [DEPTH:1]                  r_is_load;
   logic [DEPTH:1][REG_ADDR_W-1:0]  r_dst;
   logic [CNT_W-1:0]                r_stall_cnt;

   logic [SEL_W-1:0] w_rs_sel;
   logic [SEL_W-1:0] w_rt_sel;
   logic             w_rs_wait;
   logic             w_rt_wait;
   logic             w_rs_zero;
   logic             w_rt_zero;
   logic             w_hazard;
   logic             w_stall;
   logic             w_issue;

   assign w_rs_zero = (ZERO_REG_EN != 0) && (id_rs == '0);
   assign w_rt_zero = (ZERO_REG_EN != 0) && (id_rt == '0);

   // Youngest-match search per operand: scan oldest to youngest so the lowest k wins.
   always_comb begin
      w_rs_sel  = '0;
      w_rt_sel  = '0;
      w_rs_wait = 1'b0;
      w_rt_wait = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (id_use_rs && !w_rs_zero && r_valid[k] && (r_dst[k] == id_rs)) begin
            w_rs_sel  = SEL_W'(k);
            w_rs_wait = r_is_load[k] && (k < LOAD_LAT);
         end
         if (id_use_rt && !w_rt_zero && r_valid[k] && (r_dst[k] == id_rt)) begin
            w_rt_sel  = SEL_W'(k);
            w_rt_wait = r_is_load[k] && (k < LOAD_LAT);
         end
      end
   end

   // Flush overrides both hazard and memory hold; everything is quiet in reset.
   assign w_hazard = id_valid && (w_rs_wait || w_rt_wait);
   assign w_stall  = rst_n && (w_hazard || mem_hold) && !id_flush;
   assign w_issue  = rst_n && id_valid && !w_stall && !id_flush;

   assign issue       = w_issue;
   assign stall_id    = w_stall;
   // A not-yet-ready match has nothing valid to forward, so it reports 0.
   assign fwd_rs_sel  = (!rst_n || w_rs_wait) ? '0 : w_rs_sel;
   assign fwd_rt_sel  = (!rst_n || w_rt_wait) ? '0 : w_rt_sel;
   assign stage_valid = r_valid;
   assign stall_count = r_stall_cnt;

   // Writer tracking: shift one stage per cycle unless memory freezes the pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= '0;
         r_is_load <= '0;
         r_dst     <= '0;
      end else if (!mem_hold) begin
         for (int k = DEPTH; k >= 2; k--) begin
            r_valid[k]   <= r_valid[k-1];
            r_is_load[k] <= r_is_load[k-1];
            r_dst[k]     <= r_dst[k-1];
         end
         r_valid[1]   <= w_issue && id_reg_write;
         r_is_load[1] <= w_issue && id_reg_write && id_is_load;
         r_dst[1]     <= id_dst;
      end
   end

   // Saturating count of stalled decode cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised hazard-detection and forwarding controller for the in-order pipeline. It tracks in-flight writers in a DEPTH-entry shift register, one entry per stage after decode. For each instruction in decode it produces the decode stall, the issue strobe and per-operand forwarding selects. Depth, register-address width and load-result latency are configurable, so pipelines deeper than the current five-stage one can be supported. It also keeps a saturating stall-cycle counter.

Parameters:
REG_ADDR_W, 4, register index width
DEPTH, 3, tracked stages after decode (1=EX/MEM reg, 2=MEM/WB reg, 3=WB)
LOAD_LAT, 2, first stage index at which load data is forwardable (1 <= LOAD_LAT <= DEPTH)
ZERO_REG_EN, 1, when 1, register 0 never creates a hazard or forward
CNT_W, 16, stall counter width
SEL_W, $clog2(DEPTH+1), forward-select width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode holds a valid instruction
id_rs  in  REG_ADDR_W  source 1 index
id_rt  in  REG_ADDR_W  source 2 index
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_dst  in  REG_ADDR_W  destination index
id_reg_write  in  1  instruction writes id_dst
id_is_load  in  1  instruction is a load (result ready at LOAD_LAT)
id_flush  in  1  squash the decode instruction (taken branch)
mem_hold  in  1  memory busy; freeze the whole tracked pipeline
issue  out  1  decode instruction advances this cycle
stall_id  out  1  hold IF/ID and PC
fwd_rs_sel  out  SEL_W  0 = register file, k = forward from stage k
fwd_rt_sel  out  SEL_W  as fwd_rs_sel for rt
stage_valid  out  DEPTH  bit k-1 = entry k holds a register writer
stall_count  out  CNT_W  saturating count of cycles with stall_id=1

Behaviour:
- Entry k fields: valid, dst, is_load. An entry is created only for id_reg_write=1 instructions; all others enter as bubbles.
- Reset (async, rst_n=0): all entries invalid, stall_count=0. Outputs during reset: issue=0, stall_id=0, fwd_*_sel=0, stage_valid=0.
- Match rule per operand: the operand is used, the entry is valid, entry.dst equals the operand index, and the operand is not register 0 when ZERO_REG_EN=1. Only the youngest (lowest k) matching entry counts.
- Readiness: a matching entry k is ready if it is not a load, or if k >= LOAD_LAT. Ready: fwd_sel=k. No match: fwd_sel=0.
- hazard = id_valid and some used operand's youngest match is not ready.
- stall_id = (hazard or mem_hold) and not id_flush.
- issue = id_valid and not stall_id and not id_flush.
- Combinational outputs depend only on current inputs and registered entries. Zero-cycle latency from inputs.
- Shift, when mem_hold=0: entry k+1 <= entry k for k = 1..DEPTH-1, entry DEPTH falls off. Entry 1 <= {1, id_dst, id_is_load} when issue and id_reg_write; otherwise entry 1 becomes a bubble.
- mem_hold=1: no entry changes, issue=0, stall_id=1 (unless id_flush). Forward selects stay computed from the frozen entries.
- id_flush has priority over hazard and mem_hold for issue and stall_id. It never modifies existing entries.
- Simultaneous flush and mem_hold: entries frozen, issue=0, stall_id=0.
- Writes leaving entry DEPTH are visible through register-file write-before-read. The unit never forwards beyond DEPTH.
- stall_count increments on every cycle with stall_id=1 and saturates at 2^CNT_W-1.
- Reset asserted mid-stall clears entries and the counter immediately. After reset release, the first instruction sees no hazards.

Test Plan:
- ADD r3 issues, then SUB r4,r3,r5 the next cycle (defaults) -> no stall, fwd_rs_sel=1. One cycle later, a reader of r3 gets fwd_*_sel=2.
- LW r2, immediately followed by ADD r6,r2,r2 -> stall_id=1 for exactly 1 cycle, stall_count=1. Then issue=1 with fwd_rs_sel=fwd_rt_sel=2.
- With LOAD_LAT=3, DEPTH=4, a load followed by a user -> 2 stall cycles, then fwd_sel=3. At DEPTH=4, the instruction four slots later sees fwd_sel=4.
- Writers to r1 at entries 1 and 2, reader of r1 -> fwd_rs_sel=1 (youngest wins). Write to r0 followed by a reader of r0 with ZERO_REG_EN=1 -> fwd_sel=0, no stall.
- mem_hold high for 3 cycles with a load in entry 1 -> stage_valid unchanged, stall_id=1 each cycle, stall_count +3. id_flush during a load-use hazard -> issue=0, stall_id=0, entry 1 becomes a bubble.
- rst_n dropped while a load-use stall is active -> stage_valid=0, stall_count=0 asynchronously. The first post-reset user of that register gets fwd_sel=0.
